// File: rtl/adc_result_collector_if.sv
// Bus between the ADC/consumer side and the result collector.
interface adc_result_collector_if #(
  parameter int MATRIX_BITS = 12,
  parameter int FIFO_DEPTH  = 4
);
  logic                           conv_finished;
  logic [MATRIX_BITS-1:0]         result;
  logic                           enable_capture;
  logic [1:0]                     dec_control;
  logic [MATRIX_BITS+2:0]         data_out;
  logic                           data_valid;
  logic                           data_ready;
  logic [$clog2(FIFO_DEPTH):0]    fifo_level;
  logic                           overflow;
  logic                           clear_overflow;

  // ADC + consumer side
  modport master (
    output conv_finished, result, enable_capture, dec_control, data_ready, clear_overflow,
    input  data_out, data_valid, fifo_level, overflow
  );

  // Collector side
  modport slave (
    input  conv_finished, result, enable_capture, dec_control, data_ready, clear_overflow,
    output data_out, data_valid, fifo_level, overflow
  );
endinterface

// File: rtl/adc_result_collector.sv
// ADC result collector: edge-detects end-of-conversion, sums 1/2/4/8 results
// per output word and queues the sums in a small FIFO with sticky overflow.
module adc_result_collector #(
  parameter int MATRIX_BITS = 12,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  adc_result_collector_if.slave bus
);
  localparam int W  = MATRIX_BITS + 3;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(FIFO_DEPTH);

  logic           r_conv_d;
  logic [W-1:0]   r_acc;
  logic [2:0]     r_cnt;
  logic [3:0]     r_n;
  logic [W-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr, r_rd;
  logic [AW:0]    r_level;
  logic           r_ovf;

  logic           w_cap, w_take, w_push, w_pop, w_full, w_accept, w_drop;
  logic [3:0]     w_n_sel, w_n_cur, w_cnt_nxt;
  logic [W-1:0]   w_sum;

  // Capture detection, block-size selection and FIFO push/pop decisions
  always_comb begin
    w_cap  = bus.conv_finished & ~r_conv_d;
    w_take = w_cap & bus.enable_capture;
    case (bus.dec_control)
      2'b00:   w_n_sel = 4'd1;
      2'b01:   w_n_sel = 4'd2;
      2'b10:   w_n_sel = 4'd4;
      default: w_n_sel = 4'd8;
    endcase
    // the first capture of a block uses the live select, later ones the latched N
    w_n_cur   = (r_cnt == 3'd0) ? w_n_sel : r_n;
    w_cnt_nxt = {1'b0, r_cnt} + 4'd1;
    w_sum     = r_acc + {3'b000, bus.result};
    w_push    = w_take & (w_cnt_nxt == w_n_cur);
    w_full    = (r_level == LVL_FULL);
    w_pop     = (r_level != '0) & bus.data_ready;
    w_accept  = w_push & (~w_full | w_pop);
    w_drop    = w_push & w_full & ~w_pop;
  end

  // Accumulator, block counter and latched decimation factor
  always_ff @(posedge clk) begin
    if (rst) begin
      r_conv_d <= 1'b1;   // idle-high ADC flag across reset must not look like an edge
      r_acc    <= '0;
      r_cnt    <= '0;
      r_n      <= 4'd1;
    end else begin
      r_conv_d <= bus.conv_finished;
      if (!bus.enable_capture) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_take) begin
        if (r_cnt == 3'd0) r_n <= w_n_sel;
        if (w_push) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= w_cnt_nxt[2:0];
        end
      end
    end
  end

  // FIFO pointers, level and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) r_wr <= r_wr + AW'(1);
      if (w_pop)    r_rd <= r_rd + AW'(1);
      case ({w_accept, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
      // a new drop wins over a simultaneous clear
      if (w_drop)                   r_ovf <= 1'b1;
      else if (bus.clear_overflow)  r_ovf <= 1'b0;
    end
  end

  // FIFO storage, no reset needed: level gates visibility
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr] <= w_sum;
  end

  assign bus.data_valid = (r_level != '0);
  assign bus.data_out   = (r_level != '0) ? r_mem[r_rd] : '0;
  assign bus.fifo_level = r_level;
  assign bus.overflow   = r_ovf;
endmodule

// File: tb/tb_adc_result_collector.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based model.
module tb_adc_result_collector;
  localparam int MB = 12;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adc_result_collector_if #(.MATRIX_BITS(MB), .FIFO_DEPTH(FD)) bus ();

  adc_result_collector #(.MATRIX_BITS(MB), .FIFO_DEPTH(FD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int q[$];
  bit m_ovf  = 1'b0;
  bit m_prev = 1'b1;
  int m_acc  = 0;
  int m_cnt  = 0;
  int m_n    = 1;

  always @(posedge clk) begin
    bit pop, cap, push;
    int word;
    if (rst) begin
      q.delete();
      m_ovf = 0; m_prev = 1; m_acc = 0; m_cnt = 0; m_n = 1;
    end else begin
      pop  = (q.size() > 0) && bus.data_ready;
      cap  = bus.conv_finished && !m_prev;
      m_prev = bus.conv_finished;
      push = 0;
      word = 0;
      if (!bus.enable_capture) begin
        m_acc = 0; m_cnt = 0;
      end else if (cap) begin
        if (m_cnt == 0) m_n = 1 << bus.dec_control;
        m_acc += int'(bus.result);
        m_cnt++;
        if (m_cnt == m_n) begin
          push = 1; word = m_acc; m_acc = 0; m_cnt = 0;
        end
      end
      if (bus.clear_overflow) m_ovf = 0;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < FD) q.push_back(word);
        else m_ovf = 1;
      end
    end
  end

  // compare DUT against model every cycle, mid-period
  always @(negedge clk) begin
    if (chk_en) begin
      chk("data_valid", int'(bus.data_valid), int'(q.size() > 0));
      chk("data_out",   int'(bus.data_out),   (q.size() > 0) ? q[0] : 0);
      chk("fifo_level", int'(bus.fifo_level), q.size());
      chk("overflow",   int'(bus.overflow),   int'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic conv(input int res);
    bus.result = MB'(res);
    bus.conv_finished = 1'b1;
    tick();
    bus.conv_finished = 1'b0;
    tick();
  endtask

  task automatic drain();
    bus.data_ready = 1'b1;
    repeat (FD + 1) tick();
    bus.data_ready = 1'b0;
  endtask

  initial begin
    bus.conv_finished  = 1'b1;
    bus.result         = '0;
    bus.enable_capture = 1'b1;
    bus.dec_control    = 2'b00;
    bus.data_ready     = 1'b0;
    bus.clear_overflow = 1'b0;

    // reset with the ADC flag idle-high
    repeat (3) tick();
    chk_en = 1'b1;
    chk("rst_level", int'(bus.fifo_level), 0);
    chk("rst_valid", int'(bus.data_valid), 0);
    chk("rst_ovf",   int'(bus.overflow), 0);
    rst = 1'b0;
    repeat (10) tick();
    chk("idle_high_no_capture", int'(bus.fifo_level), 0);
    bus.conv_finished = 1'b0;
    tick();

    // single conversion, N=1, consumer ready: visible for exactly one cycle
    bus.data_ready = 1'b1;
    bus.result = 12'hABC;
    bus.conv_finished = 1'b1;
    tick();
    chk("n1_valid", int'(bus.data_valid), 1);
    chk("n1_data",  int'(bus.data_out), 'h0ABC);
    bus.conv_finished = 1'b0;
    tick();
    chk("n1_one_cycle", int'(bus.data_valid), 0);
    chk("n1_zero_out",  int'(bus.data_out), 0);
    bus.data_ready = 1'b0;

    // N=8 of full scale
    bus.dec_control = 2'b11;
    for (int i = 0; i < 8; i++) conv('hFFF);
    chk("n8_level", int'(bus.fifo_level), 1);
    chk("n8_data",  int'(bus.data_out), 'h7FF8);
    drain();
    for (int i = 0; i < 3; i++) conv('hFFF);
    bus.dec_control = 2'b00;
    for (int i = 0; i < 5; i++) conv('hFFF);
    chk("n8_midchg_level", int'(bus.fifo_level), 1);
    chk("n8_midchg_data",  int'(bus.data_out), 'h7FF8);
    drain();

    // overflow: 5 words into a depth-4 FIFO
    for (int i = 1; i <= 5; i++) conv(i);
    chk("ovf_level", int'(bus.fifo_level), 4);
    chk("ovf_flag",  int'(bus.overflow), 1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_drain", int'(bus.data_out), i);
      bus.data_ready = 1'b1;
      tick();
      bus.data_ready = 1'b0;
    end
    chk("ovf_empty", int'(bus.data_valid), 0);
    bus.clear_overflow = 1'b1;
    tick();
    bus.clear_overflow = 1'b0;
    chk("ovf_cleared", int'(bus.overflow), 0);

    // full FIFO: push and pop on the same edge
    for (int i = 10; i <= 13; i++) conv(i);
    bus.result = MB'(14);
    bus.conv_finished = 1'b1;
    bus.data_ready = 1'b1;
    tick();
    bus.data_ready = 1'b0;
    bus.conv_finished = 1'b0;
    chk("pp_level", int'(bus.fifo_level), 4);
    chk("pp_ovf",   int'(bus.overflow), 0);
    for (int i = 11; i <= 14; i++) begin
      chk("pp_order", int'(bus.data_out), i);
      bus.data_ready = 1'b1;
      tick();
      bus.data_ready = 1'b0;
    end

    // enable dropped mid-block discards partial sum
    bus.dec_control = 2'b10;
    for (int i = 0; i < 3; i++) conv(100);
    bus.enable_capture = 1'b0;
    tick();
    bus.enable_capture = 1'b1;
    chk("en_drop_no_word", int'(bus.fifo_level), 0);
    for (int i = 0; i < 4; i++) conv(1);
    chk("en_fresh_level", int'(bus.fifo_level), 1);
    chk("en_fresh_data",  int'(bus.data_out), 4);
    drain();

    // reset with FIFO full and overflow set
    bus.dec_control = 2'b00;
    for (int i = 1; i <= 5; i++) conv(i);
    chk("pre_rst_ovf", int'(bus.overflow), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_full_level", int'(bus.fifo_level), 0);
    chk("rst_full_valid", int'(bus.data_valid), 0);
    chk("rst_full_out",   int'(bus.data_out), 0);
    chk("rst_full_ovf",   int'(bus.overflow), 0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.conv_finished  = ($urandom_range(0, 9) < 4);
      bus.result         = MB'($urandom);
      bus.enable_capture = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 15) == 0) bus.dec_control = 2'($urandom);
      bus.data_ready     = ($urandom_range(0, 9) < 3);
      bus.clear_overflow = ($urandom_range(0, 39) == 0);
      rst                = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/adc_result_collector.md
ADC_RESULT_COLLECTOR -- requirements
Module: adc_result_collector

Interface
REQ-001 Parameter: MATRIX_BITS, default 12, width of the ADC conversion result.
REQ-002 Parameter: FIFO_DEPTH, default 4, output FIFO depth; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 conv_finished  input  1  ADC end-of-conversion flag; high while the ADC samples, with result stable.
REQ-006 result  input  MATRIX_BITS  ADC conversion result, binary-weighted.
REQ-007 enable_capture  input  1  1 = accept conversions; 0 = ignore them and discard any partial accumulation.
REQ-008 dec_control  input  2  decimation factor select: 00=1, 01=2, 10=4, 11=8 results summed per output word.
REQ-009 data_out  output  MATRIX_BITS+3  FIFO head word (sum of results).
REQ-010 data_valid  output  1  FIFO non-empty.
REQ-011 data_ready  input  1  consumer accepts data_out.
REQ-012 fifo_level  output  clog2(FIFO_DEPTH)+1  number of words held.
REQ-013 overflow  output  1  sticky flag: an output word was dropped.
REQ-014 clear_overflow  input  1  synchronous clear of overflow.

Function
REQ-015 Capture event: conv_finished high in the current cycle and low in the previous cycle (registered copy conv_d).
REQ-016 A capture event with enable_capture=1 SHALL add zero-extended result to the accumulator acc (MATRIX_BITS+3 bits) and increment the block counter cnt (3 bits).
REQ-017 Decimation factor N SHALL be latched from dec_control only when cnt=0 and a capture event occurs; changes mid-block SHALL NOT affect the current block.
REQ-018 When a capture event makes cnt reach N, the block completes: acc+result SHALL be pushed to the FIFO on that same clock edge, and acc and cnt SHALL clear to 0.
REQ-019 Latency: with N=1, capture event in cycle T -> data_valid=1 and data_out=result in cycle T+1 (FIFO previously empty).
REQ-020 Arithmetic: plain unsigned sum, no scaling or rounding; the maximum sum 8*(2^MATRIX_BITS-1) SHALL fit without wrap.
REQ-021 Pop: data_valid=1 and data_ready=1 at a clock edge SHALL remove the head word.
REQ-022 Push SHALL be accepted when fifo_level<FIFO_DEPTH, or when the FIFO is full and a pop occurs in the same cycle (level unchanged, order preserved).
REQ-023 Push to a full FIFO with no simultaneous pop SHALL drop the new word, leave FIFO contents unchanged, and set overflow=1.
REQ-024 overflow SHALL stay set until clear_overflow=1; if clear_overflow and a new drop coincide, overflow SHALL remain 1.
REQ-025 data_out SHALL be all zeros whenever data_valid=0.
REQ-026 Pop on an empty FIFO SHALL have no effect; fifo_level SHALL never underflow or exceed FIFO_DEPTH.
REQ-027 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 With enable_capture=0: acc and cnt SHALL clear to 0 and capture events SHALL be ignored; the FIFO SHALL still drain normally.
REQ-029 A conv_finished level held high for several cycles SHALL produce exactly one capture event.

Reset
REQ-030 With rst=1 at a clock edge: FIFO SHALL be emptied, acc=0, cnt=0, N=1, overflow=0; data_out=0, data_valid=0, fifo_level=0.
REQ-031 conv_d SHALL reset to 1, so that a conv_finished that is high during and after reset (the ADC idle state) causes no capture.
REQ-032 rst SHALL take priority over every other input, including mid-block and with the FIFO full.

Verification
REQ-033 dec_control=00, single conversion with result=0xABC, data_ready=1 -> data_out=0x0ABC with data_valid=1 for exactly one cycle, starting one cycle after the capture event.
REQ-034 dec_control=11, 8 conversions with result=0xFFF -> exactly one word 0x7FF8; dec_control changed to 00 after the 3rd conversion -> still one word 0x7FF8.
REQ-035 data_ready=0, dec=00, 5 conversions with results 1..5 -> fifo_level=4 and overflow=1; draining yields 1,2,3,4; clear_overflow -> overflow=0.
REQ-036 FIFO full, push and pop in the same cycle -> fifo_level stays 4, overflow stays 0, order preserved.
REQ-037 conv_finished high through reset release and held 10 cycles -> no capture; enable_capture dropped after 3 of 4 conversions (dec=10) -> no word produced, and the next block starts from acc=0.
REQ-038 rst asserted with the FIFO full and overflow=1 -> the next cycle shows fifo_level=0, data_valid=0, data_out=0, overflow=0.
